uart_tx_core: RTL and testbench

//  UART transmitter. Serializes one parallel byte per request into an asynchronous frame:

---
 rtl/uart_tx_pkg.sv | 19 +
 rtl/uart_tx_parity.sv | 16 +
 rtl/uart_tx_core.sv | 121 ++++++++++++
 tb/tb_uart_tx_core.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the UART transmitter.
// Two-stop-bit frames are selected with the UART_TX_TWO_STOP_EN macro (see uart_tx_core).
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;

endpackage

// File: rtl/uart_tx_parity.sv
// Combinational parity generator: even parity makes the total count of ones even.
module uart_tx_parity
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    always_comb begin
        par_bit = (par_typ == PAR_ODD) ? ~^data : ^data;
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter, one bit per clock: start, data LSB first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_core
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK_TOP,
    input  logic                  RST_TOP,
    input  logic [DATA_WIDTH-1:0] P_DATA_TOP,
    input  logic                  Data_Valid_TOP,
    input  logic                  PAR_EN_TOP,
    input  logic                  PAR_TYP_TOP,
    output logic                  TX_OUT_TOP,
    output logic                  busy_TOP
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic [CNT_W-1:0]        bit_cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic                    last_bit;
    logic                    par_bit;
`ifdef UART_TX_TWO_STOP_EN
    logic                    second_stop;
`endif

    assign cnt_next = bit_cnt + CNT_W'(1);
    assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

    uart_tx_parity #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data    (data_q),
        .par_typ (par_typ_q),
        .par_bit (par_bit)
    );

    // TX_OUT_TOP always carries the bit of the current state, so each branch
    // loads the level for the state being entered.
    always_ff @(posedge CLK_TOP or posedge RST_TOP) begin
        if (RST_TOP) begin
            state      <= IDLE;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            bit_cnt    <= '0;
            TX_OUT_TOP <= IDLE_LEVEL;
            busy_TOP   <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            second_stop <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    TX_OUT_TOP <= IDLE_LEVEL;
                    busy_TOP   <= 1'b0;
                    if (Data_Valid_TOP) begin
                        data_q     <= P_DATA_TOP;
                        par_en_q   <= PAR_EN_TOP;
                        par_typ_q  <= PAR_TYP_TOP;
                        TX_OUT_TOP <= START_BIT;
                        busy_TOP   <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    bit_cnt    <= '0;
                    TX_OUT_TOP <= data_q[0];
                    state      <= DATA;
                end
                DATA: begin
                    if (last_bit) begin
                        bit_cnt <= '0;
                        if (par_en_q) begin
                            TX_OUT_TOP <= par_bit;
                            state      <= PARITY;
                        end else begin
                            TX_OUT_TOP <= STOP_BIT;
                            state      <= STOP;
                        end
                    end else begin
                        bit_cnt    <= cnt_next;
                        TX_OUT_TOP <= data_q[cnt_next];
                    end
                end
                PARITY: begin
                    TX_OUT_TOP <= STOP_BIT;
                    state      <= STOP;
                end
                STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                    if (!second_stop) begin
                        second_stop <= 1'b1;
                        TX_OUT_TOP  <= STOP_BIT;
                    end else begin
                        second_stop <= 1'b0;
                        TX_OUT_TOP  <= IDLE_LEVEL;
                        busy_TOP    <= 1'b0;
                        state       <= IDLE;
                    end
`else
                    TX_OUT_TOP <= IDLE_LEVEL;
                    busy_TOP   <= 1'b0;
                    state      <= IDLE;
`endif
                end
                default: begin
                    TX_OUT_TOP <= IDLE_LEVEL;
                    busy_TOP   <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: frames are written out bit by bit as strings,
// first character is the start bit seen at the first negedge after the request.
module tb_uart_tx_core;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       tx_out;
    logic       busy;

    int vectors;
    int miscompares;

    logic tx_obs[$];
    logic busy_obs[$];

`ifdef UART_TX_TWO_STOP_EN
    localparam string EXTRA_STOP = "1";
`else
    localparam string EXTRA_STOP = "";
`endif
    localparam string IDLE_TAIL = "111";

    uart_tx_core #(
        .DATA_WIDTH(8)
    ) dut (
        .CLK_TOP        (clk),
        .RST_TOP        (rst),
        .P_DATA_TOP     (p_data),
        .Data_Valid_TOP (data_valid),
        .PAR_EN_TOP     (par_en),
        .PAR_TYP_TOP    (par_typ),
        .TX_OUT_TOP     (tx_out),
        .busy_TOP       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge. Requests one frame and records n negedge samples,
    // starting with the start bit. At sample index inject_at a stray request
    // with different data/parity settings is pulsed for one cycle.
    task automatic drive_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                               input int n, input int inject_at);
        tx_obs.delete();
        busy_obs.delete();
        p_data     = d;
        par_en     = pen;
        par_typ    = ptyp;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            tx_obs.push_back(tx_out);
            busy_obs.push_back(busy);
            if (k == inject_at) begin
                data_valid = 1'b1;
                p_data     = 8'h55;
                par_en     = ~pen;
                par_typ    = ~ptyp;
            end else begin
                data_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_held: tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_release_idle: tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
            miscompares++;
        end
    endtask

    task automatic test_no_parity;
        string frame;
        string full;
        int    flen;
        // 0xC8 LSB first = 0001_0011
        frame = {"0", "00010011", "1", EXTRA_STOP};
        flen  = frame.len();
        for (int pass = 0; pass < 2; pass++) begin
            full = {frame, IDLE_TAIL};
            drive_frame(8'hC8, 1'b0, pass[0], full.len(), -1);
            for (int k = 0; k < full.len(); k++) begin
                vectors++;
                if (tx_obs[k] !== (full[k] == 8'h31) || busy_obs[k] !== (k < flen)) begin
                    $display("FAIL no_parity_typ%0d bit%0d: tx=%b busy=%b, want tx=%b busy=%b",
                             pass, k, tx_obs[k], busy_obs[k], full[k] == 8'h31, k < flen);
                    miscompares++;
                end
            end
        end
    endtask

    task automatic test_parity;
        logic [7:0] d_tab[3];
        logic       typ_tab[3];
        string      frame_tab[3];
        string      full;
        int         flen;
        // 0xA1 odd: 3 ones -> 0; 0xF3 even: 6 ones -> 0; 0x28 odd: 2 ones -> 1
        d_tab[0] = 8'hA1; typ_tab[0] = 1'b1; frame_tab[0] = {"0", "10000101", "0", "1"};
        d_tab[1] = 8'hF3; typ_tab[1] = 1'b0; frame_tab[1] = {"0", "11001111", "0", "1"};
        d_tab[2] = 8'h28; typ_tab[2] = 1'b1; frame_tab[2] = {"0", "00010100", "1", "1"};
        for (int t = 0; t < 3; t++) begin
            full = {frame_tab[t], EXTRA_STOP};
            flen = full.len();
            full = {full, IDLE_TAIL};
            drive_frame(d_tab[t], 1'b1, typ_tab[t], full.len(), -1);
            for (int k = 0; k < full.len(); k++) begin
                vectors++;
                if (tx_obs[k] !== (full[k] == 8'h31) || busy_obs[k] !== (k < flen)) begin
                    $display("FAIL parity_%02h bit%0d: tx=%b busy=%b, want tx=%b busy=%b",
                             d_tab[t], k, tx_obs[k], busy_obs[k], full[k] == 8'h31, k < flen);
                    miscompares++;
                end
            end
        end
    endtask

    task automatic test_ignore_busy;
        string full;
        int    flen;
        full = {"0", "10000101", "0", "1", EXTRA_STOP};
        flen = full.len();
        full = {full, IDLE_TAIL};
        drive_frame(8'hA1, 1'b1, 1'b1, full.len(), 3);
        for (int k = 0; k < full.len(); k++) begin
            vectors++;
            if (tx_obs[k] !== (full[k] == 8'h31) || busy_obs[k] !== (k < flen)) begin
                $display("FAIL ignore_busy bit%0d: tx=%b busy=%b, want tx=%b busy=%b",
                         k, tx_obs[k], busy_obs[k], full[k] == 8'h31, k < flen);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        string full;
        int    flen;
        p_data     = 8'hA1;
        par_en     = 1'b1;
        par_typ    = 1'b1;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            $display("FAIL mid_frame_busy: busy=%b, want 1", busy);
            miscompares++;
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_abort: tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_abort_idle: tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
            miscompares++;
        end
        full = {"0", "00010011", "1", EXTRA_STOP};
        flen = full.len();
        full = {full, IDLE_TAIL};
        drive_frame(8'hC8, 1'b0, 1'b0, full.len(), -1);
        for (int k = 0; k < full.len(); k++) begin
            vectors++;
            if (tx_obs[k] !== (full[k] == 8'h31) || busy_obs[k] !== (k < flen)) begin
                $display("FAIL after_reset bit%0d: tx=%b busy=%b, want tx=%b busy=%b",
                         k, tx_obs[k], busy_obs[k], full[k] == 8'h31, k < flen);
                miscompares++;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        p_data      = 8'h00;
        data_valid  = 1'b0;
        par_en      = 1'b0;
        par_typ     = 1'b0;
        @(negedge clk);
        test_reset();
        test_no_parity();
        test_parity();
        test_ignore_busy();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
